// File: rtl/rca_accumulator.sv
// Batch accumulator: sums COUNT unsigned words through a ripple-carry adder and
// presents the modulo-2^WIDTH total plus a sticky overflow flag on a valid/ready port.
module rca_accumulator #(
    parameter int WIDTH = 32,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);

    // COUNT = 1 would give a zero-width counter, so keep at least one bit.
    localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic             ovf, ovf_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] sum;
    logic             carry;

    rca #(.WIDTH(WIDTH)) adder (
        .a (acc),
        .b (in_data),
        .s (sum),
        .c (carry)
    );

    assign in_ready  = (state == ACCUM) && !clear;
    assign out_valid = (state == DONE);
    assign out_sum   = acc;
    assign out_carry = ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            ovf   <= ovf_d;
            cnt   <= cnt_d;
        end
    end

    // clear outranks everything, so a pending result in DONE is simply dropped.
    always_comb begin
        state_d = state;
        acc_d   = acc;
        ovf_d   = ovf;
        cnt_d   = cnt;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc_d = sum;
                        ovf_d = ovf | carry;
                        if (cnt == LAST) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

endmodule

// Plain WIDTH-bit ripple-carry adder; carry-in is tied low.
module rca #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    logic [WIDTH:0] ripple;

    assign ripple[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign s[i]          = a[i] ^ b[i] ^ ripple[i];
        assign ripple[i + 1] = (a[i] & b[i]) | (ripple[i] & (a[i] ^ b[i]));
    end

    assign c = ripple[WIDTH];

endmodule
